// File: rtl/hazard_pkg.sv
// Shared constants and shadow-entry types for the pipeline hazard unit.
// Forward selects are also consumed by the execute-stage ALU mux.
package hazard_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FW_REG = 2'b00;
    localparam logic [1:0] FW_WB  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_to_reg;
    } e_entry_t;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_to_reg;
    } m_entry_t;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } w_entry_t;

    function automatic m_entry_t to_m(e_entry_t e);
        m_entry_t m;
        m.dst        = e.dst;
        m.reg_write  = e.reg_write;
        m.mem_to_reg = e.mem_to_reg;
        return m;
    endfunction

    function automatic w_entry_t to_w(m_entry_t m);
        w_entry_t w;
        w.dst       = m.dst;
        w.reg_write = m.reg_write;
        return w;
    endfunction

    // Loads in MEM have no data yet, so they never forward from there.
    function automatic logic [1:0] fw_sel(
        logic              rd_en,
        logic [REG_AW-1:0] src,
        m_entry_t          m,
        w_entry_t          w
    );
        logic m_hit;
        logic w_hit;
        m_hit = rd_en && m.reg_write && !m.mem_to_reg &&
                (m.dst != '0) && (m.dst == src);
        w_hit = rd_en && w.reg_write &&
                (w.dst != '0) && (w.dst == src);
        if (m_hit)      return FW_MEM;
        else if (w_hit) return FW_WB;
        else            return FW_REG;
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copies of the EX, MEM and WB instruction register fields.
// A flush loads an all-zero bubble into the EX entry.
module hazard_shadow_pipe
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush_e,
    input  e_entry_t e_in,
    output e_entry_t e_q,
    output m_entry_t m_q,
    output w_entry_t w_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= flush_e ? '0 : e_in;
            m_q <= to_m(e_q);
            w_q <= to_w(m_q);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch flush control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_AW
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_addrD,
    input  logic [REG_ADDR_W-1:0] rt_addrD,
    input  logic [REG_ADDR_W-1:0] rd_addrD,
    input  logic                  uses_rsD,
    input  logic                  uses_rtD,
    input  logic                  reg_dstD,
    input  logic                  reg_writeD,
    input  logic                  mem_to_regD,
    input  logic                  branch_takenE,
    output logic [1:0]            fw_alu1,
    output logic [1:0]            fw_alu2,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    e_entry_t e_in;
    e_entry_t e_q;
    m_entry_t m_q;
    w_entry_t w_q;
    logic     e_load;
    logic     lduse;

    always_comb begin
        e_in            = '0;
        e_in.valid      = 1'b1;
        e_in.rs         = rs_addrD;
        e_in.rt         = rt_addrD;
        e_in.uses_rs    = uses_rsD;
        e_in.uses_rt    = uses_rtD;
        e_in.dst        = reg_dstD ? rd_addrD : rt_addrD;
        e_in.reg_write  = reg_writeD;
        e_in.mem_to_reg = mem_to_regD;
    end

    hazard_shadow_pipe u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_e (flush_e),
        .e_in    (e_in),
        .e_q     (e_q),
        .m_q     (m_q),
        .w_q     (w_q)
    );

    assign fw_alu1 = fw_sel(e_q.valid && e_q.uses_rs, e_q.rs, m_q, w_q);
    assign fw_alu2 = fw_sel(e_q.valid && e_q.uses_rt, e_q.rt, m_q, w_q);

    assign e_load = e_q.valid && e_q.reg_write &&
                    e_q.mem_to_reg && (e_q.dst != '0);

    assign lduse = e_load &&
                   ((uses_rsD && (rs_addrD == e_q.dst)) ||
                    (uses_rtD && (rt_addrD == e_q.dst)));

    // A taken branch squashes the consumer, so it must not also stall.
    assign stall_f = lduse && !branch_takenE;
    assign stall_d = stall_f;
    assign flush_d = branch_takenE;
    assign flush_e = lduse || branch_takenE;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven and randomized checks of hazard_unit against a stage model.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_unit;

    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_addrD, rt_addrD, rd_addrD;
    logic       uses_rsD, uses_rtD, reg_dstD, reg_writeD, mem_to_regD;
    logic       branch_takenE;
    logic [1:0] fw_alu1, fw_alu2;
    logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_ADDR_W(5)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .rd_addrD(rd_addrD),
        .uses_rsD(uses_rsD), .uses_rtD(uses_rtD), .reg_dstD(reg_dstD),
        .reg_writeD(reg_writeD), .mem_to_regD(mem_to_regD),
        .branch_takenE(branch_takenE),
        .fw_alu1(fw_alu1), .fw_alu2(fw_alu2),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       urs, urt, rdst, rw, mtr;
    } ins_t;

    typedef struct {
        bit         rst;
        ins_t       d;
        bit         br;
        logic [7:0] exp;
        int         sc, fc;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    vec_t tab[$];

    function automatic ins_t r_op(int rd, int rs, int rt);
        ins_t i = '{rs: 5'(rs), rt: 5'(rt), rd: 5'(rd), urs: 1, urt: 1,
                    rdst: 1, rw: 1, mtr: 0};
        return i;
    endfunction

    function automatic ins_t i_op(int rt, int rs);
        ins_t i = '{rs: 5'(rs), rt: 5'(rt), rd: 0, urs: 1, urt: 0,
                    rdst: 0, rw: 1, mtr: 0};
        return i;
    endfunction

    function automatic ins_t lw_op(int rt, int rs);
        ins_t i = i_op(rt, rs);
        i.mtr = 1;
        return i;
    endfunction

    function automatic vec_t row(bit rst, ins_t d, bit br,
                                 logic [1:0] f1, logic [1:0] f2,
                                 bit st, bit fd, bit fe, int sc, int fc);
        vec_t v;
        v.rst = rst; v.d = d; v.br = br;
        v.exp = {f1, f2, st, st, fd, fe};
        v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(logic [7:0] o, int sc, int fc);
`ifdef HAZARD_PERF_CNT_EN
        return {18'd0, 3'(sc), 3'(fc), o};
`else
        if (sc < 0 || fc < 0) return 32'hffff_ffff;
        return {24'd0, o};
`endif
    endfunction

    function automatic logic [31:0] dut_out();
        logic [7:0] o;
        o = {fw_alu1, fw_alu2, stall_f, stall_d, flush_d, flush_e};
`ifdef HAZARD_PERF_CNT_EN
        return {18'd0, stall_cnt, flush_cnt, o};
`else
        return {24'd0, o};
`endif
    endfunction

    task automatic check(string name, logic [31:0] exp);
        logic [31:0] act;
        act = dut_out();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(ins_t d, bit br);
        rs_addrD = d.rs; rt_addrD = d.rt; rd_addrD = d.rd;
        uses_rsD = d.urs; uses_rtD = d.urt; reg_dstD = d.rdst;
        reg_writeD = d.rw; mem_to_regD = d.mtr; branch_takenE = br;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Behavioural reference: one instruction record per stage.
    ins_t ex, mm, wb;
    int   msc, mfc;

    function automatic logic [4:0] dst_of(ins_t i);
        return i.rdst ? i.rd : i.rt;
    endfunction

    function automatic logic [1:0] pick(bit en, logic [4:0] r);
        if (!en || r == 0) return 2'b00;
        if (mm.rw && !mm.mtr && dst_of(mm) == r) return 2'b10;
        if (wb.rw && dst_of(wb) == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_lduse(ins_t d);
        logic [4:0] t;
        t = dst_of(ex);
        return ex.rw && ex.mtr && t != 0 &&
               ((d.urs && d.rs == t) || (d.urt && d.rt == t));
    endfunction

    initial begin
        ins_t nop;
        ins_t d;
        bit   br, st, fe, hold;
        nop = '0;

        // add/sub/or forwarding chain
        tab.push_back(row(1, r_op(3,1,2), 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(4,3,5), 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(6,3,3), 0, 2, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, nop,         0, 1, 1, 0, 0, 0, 0, 0));
        tab.push_back(row(0, nop,         0, 0, 0, 0, 0, 0, 0, 0));
        // lw then dependent add
        tab.push_back(row(1, lw_op(8,9),   0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(10,8,1), 0, 0, 0, 1, 0, 1, 0, 0));
        tab.push_back(row(0, r_op(10,8,1), 0, 0, 0, 0, 0, 0, 1, 0));
        tab.push_back(row(0, nop,          0, 1, 0, 0, 0, 0, 1, 0));
        // writes to $0 never forward or stall
        tab.push_back(row(1, i_op(0,1),   0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(5,0,0), 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, lw_op(0,1),  0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(5,0,0), 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, nop,         0, 0, 0, 0, 0, 0, 0, 0));
        // $7 in both MEM and WB: MEM wins
        tab.push_back(row(1, i_op(7,1),   0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, i_op(7,7),   0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(2,7,7), 0, 2, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, nop,         0, 2, 2, 0, 0, 0, 0, 0));
        tab.push_back(row(0, nop,         0, 0, 0, 0, 0, 0, 0, 0));
        // branch coinciding with load-use
        tab.push_back(row(1, lw_op(8,9),   0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, r_op(10,8,1), 1, 0, 0, 0, 1, 1, 0, 0));
        tab.push_back(row(0, nop,          0, 0, 0, 0, 0, 0, 0, 1));
        // chained loads: one stall per dependent pair
        tab.push_back(row(1, lw_op(8,9),  0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(row(0, lw_op(9,8),  0, 0, 0, 1, 0, 1, 0, 0));
        tab.push_back(row(0, lw_op(9,8),  0, 0, 0, 0, 0, 0, 1, 0));
        tab.push_back(row(0, r_op(1,9,0), 0, 1, 0, 1, 0, 1, 1, 0));
        tab.push_back(row(0, r_op(1,9,0), 0, 0, 0, 0, 0, 0, 2, 0));
        tab.push_back(row(0, nop,         0, 1, 0, 0, 0, 0, 2, 0));

        rst_n = 1'b0;
        drive(nop, 0);
        @(negedge clk);
        check("reset_state", pack_exp(8'h00, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst) pulse_reset();
            drive(tab[i].d, tab[i].br);
            @(negedge clk);
            check($sformatf("row%0d", i),
                  pack_exp(tab[i].exp, tab[i].sc, tab[i].fc));
            @(posedge clk);
            #1;
        end

        // reset while a load sits in E with a pending consumer
        pulse_reset();
        drive(lw_op(8,9), 0);
        @(posedge clk);
        #1 drive(r_op(10,8,1), 0);
        @(negedge clk);
        check("pre_reset_stall", pack_exp(8'b0000_1101, 0, 0));
        rst_n = 1'b0;
        #1;
        check("in_reset", pack_exp(8'h00, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_nostall", pack_exp(8'h00, 0, 0));
        @(posedge clk);
        #1 drive(nop, 0);
        @(negedge clk);
        check("post_reset_nofw", pack_exp(8'h00, 0, 0));
        @(posedge clk);
        #1;

        // randomized run against the stage model
        pulse_reset();
        ex = '0; mm = '0; wb = '0; msc = 0; mfc = 0;
        hold = 0; d = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] e;
            if ($urandom_range(0, 249) == 0) begin
                pulse_reset();
                ex = '0; mm = '0; wb = '0; msc = 0; mfc = 0;
                hold = 0;
            end
            if (!hold) begin
                d.rs   = 5'($urandom_range(0, 3));
                d.rt   = 5'($urandom_range(0, 3));
                d.rd   = 5'($urandom_range(0, 3));
                d.urs  = 1'($urandom);
                d.urt  = 1'($urandom);
                d.rdst = 1'($urandom);
                d.rw   = ($urandom_range(0, 3) != 0);
                d.mtr  = ($urandom_range(0, 2) == 0);
            end
            br = ($urandom_range(0, 9) == 0);
            drive(d, br);
            st = model_lduse(d) && !br;
            fe = model_lduse(d) || br;
            e = {pick(ex.urs, ex.rs), pick(ex.urt, ex.rt), st, st, br, fe};
            @(negedge clk);
            check($sformatf("rand%0d", n), pack_exp(e, msc, mfc));
            @(posedge clk);
            wb = mm;
            mm = ex;
            ex = fe ? '0 : d;
            if (st && msc < (1 << CW) - 1) msc++;
            if (br && mfc < (1 << CW) - 1) mfc++;
            hold = st;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
